// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard/sequencing controller and the 5-stage pipeline datapath.
// The controller connects through the slave modport; the datapath side uses the master modport.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        idex_mem_read;
   logic [4:0]  idex_rt;
   logic        ex_branch_taken;
   logic        exmem_mem_access;
   logic        dmem_ready;
   logic        halt_req;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_bubble;
   logic        id_ex_bubble;
   logic        id_ex_hold;
   logic        ex_mem_hold;
   logic        mem_wb_bubble;
   logic        flush_all;
   logic        halted;
   logic        mem_err;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport slave (
      input  id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
             ex_branch_taken, exmem_mem_access, dmem_ready, halt_req,
      output pc_write, if_id_write, if_id_bubble, id_ex_bubble, id_ex_hold,
             ex_mem_hold, mem_wb_bubble, flush_all, halted, mem_err,
             stall_cnt, flush_cnt
   );

   modport master (
      output id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
             ex_branch_taken, exmem_mem_access, dmem_ready, halt_req,
      input  pc_write, if_id_write, if_id_bubble, id_ex_bubble, id_ex_hold,
             ex_mem_hold, mem_wb_bubble, flush_all, halted, mem_err,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: reset fill, load-use stall, branch kill,
// data-memory freeze with timeout, and orderly drain to HALT.
module pipeline_hazard_ctrl #(
   parameter int FILL_CYCLES  = 4,
   parameter int DRAIN_CYCLES = 4,
   parameter int MEM_TIMEOUT  = 255
) (
   input logic                   clk,
   input logic                   rst_n,
   pipeline_hazard_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_FILL     = 3'd0,
      S_RUN      = 3'd1,
      S_MEM_WAIT = 3'd2,
      S_DRAIN    = 3'd3,
      S_HALT     = 3'd4
   } state_t;

   localparam logic [3:0] FILL_LAST    = 4'(FILL_CYCLES - 1);
   localparam logic [3:0] DRAIN_LAST   = 4'(DRAIN_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_fill_cnt;
   logic [3:0]  r_drain_cnt;
   logic [7:0]  r_to_cnt;
   logic        r_from_drain;
   logic        r_flush_all;
   logic        r_halted;
   logic        r_mem_err;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   logic w_freeze, w_lu, w_stop, w_run_mode, w_drain_mode, w_active;
   logic w_drain_last, w_timeout, w_stall_evt, w_flush_evt, w_drain_adv;
   logic w_pc_write, w_if_id_write, w_if_id_bubble, w_id_ex_bubble;
   logic w_id_ex_hold, w_ex_mem_hold, w_mem_wb_bubble;

   assign w_freeze = bus.exmem_mem_access & ~bus.dmem_ready;
   assign w_lu     = bus.idex_mem_read & (bus.idex_rt != 5'd0) &
                     ((bus.idex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.idex_rt == bus.id_rt)));

   // Operating mode: a MEM_WAIT cycle behaves like the state that entered it once memory is ready
   always_comb begin
      w_run_mode   = 1'b0;
      w_drain_mode = 1'b0;
      w_stop       = 1'b0;
      case (r_state)
         S_RUN: begin
            w_run_mode = 1'b1;
            w_stop     = w_freeze;
         end
         S_DRAIN: begin
            w_drain_mode = 1'b1;
            w_stop       = w_freeze;
         end
         S_MEM_WAIT: begin
            w_run_mode   = ~r_from_drain;
            w_drain_mode = r_from_drain;
            w_stop       = ~bus.dmem_ready;
         end
         default: begin
            w_run_mode   = 1'b0;
            w_drain_mode = 1'b0;
            w_stop       = 1'b0;
         end
      endcase
   end

   assign w_active     = w_run_mode | w_drain_mode;
   assign w_drain_last = (r_drain_cnt == DRAIN_LAST);
   assign w_timeout    = (r_state == S_MEM_WAIT) & ~bus.dmem_ready & (r_to_cnt == TIMEOUT_LAST);
   assign w_stall_evt  = w_active & (w_stop | (~bus.ex_branch_taken & w_lu));
   assign w_flush_evt  = w_active & ~w_stop & bus.ex_branch_taken;
   assign w_drain_adv  = w_drain_mode & ~w_stop;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FILL: begin
            if (r_fill_cnt == FILL_LAST) w_next = S_RUN;
            else                         w_next = S_FILL;
         end
         S_RUN: begin
            if (w_freeze)          w_next = S_MEM_WAIT;
            else if (bus.halt_req) w_next = S_DRAIN;
            else                   w_next = S_RUN;
         end
         S_MEM_WAIT: begin
            if (w_timeout)         w_next = S_HALT;
            else if (w_stop)       w_next = S_MEM_WAIT;
            else if (r_from_drain) w_next = w_drain_last ? S_HALT : S_DRAIN;
            else if (bus.halt_req) w_next = S_DRAIN;
            else                   w_next = S_RUN;
         end
         S_DRAIN: begin
            if (w_freeze)          w_next = S_MEM_WAIT;
            else if (w_drain_last) w_next = S_HALT;
            else                   w_next = S_DRAIN;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_HALT;
      endcase
   end

   // Stall/bubble/hold outputs; in drain mode the PC stays put and IF/ID is fed nops
   always_comb begin
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_if_id_bubble  = 1'b1;
      w_id_ex_bubble  = 1'b1;
      w_id_ex_hold    = 1'b0;
      w_ex_mem_hold   = 1'b0;
      w_mem_wb_bubble = 1'b1;
      if (w_active) begin
         w_if_id_bubble  = 1'b0;
         w_id_ex_bubble  = 1'b0;
         w_mem_wb_bubble = 1'b0;
         if (w_stop) begin
            w_id_ex_hold    = 1'b1;
            w_ex_mem_hold   = 1'b1;
            w_mem_wb_bubble = 1'b1;
         end else if (bus.ex_branch_taken) begin
            w_pc_write     = w_run_mode;
            w_if_id_write  = 1'b1;
            w_if_id_bubble = 1'b1;
            w_id_ex_bubble = 1'b1;
         end else if (w_lu) begin
            w_id_ex_bubble = 1'b1;
         end else begin
            w_pc_write     = w_run_mode;
            w_if_id_write  = 1'b1;
            w_if_id_bubble = w_drain_mode;
         end
      end else begin
         w_pc_write = 1'b0;
      end
   end

   // Sequencing counters, registered status flags and saturating statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill_cnt   <= 4'd0;
         r_drain_cnt  <= 4'd0;
         r_to_cnt     <= 8'd0;
         r_from_drain <= 1'b0;
         r_flush_all  <= 1'b1;
         r_halted     <= 1'b0;
         r_mem_err    <= 1'b0;
         r_stall_cnt  <= 16'd0;
         r_flush_cnt  <= 16'd0;
      end else begin
         if (r_state == S_FILL) r_fill_cnt <= r_fill_cnt + 4'd1;
         else                   r_fill_cnt <= 4'd0;
         if (w_drain_adv) r_drain_cnt <= r_drain_cnt + 4'd1;
         else             r_drain_cnt <= r_drain_cnt;
         if ((r_state == S_MEM_WAIT) && !bus.dmem_ready) r_to_cnt <= r_to_cnt + 8'd1;
         else                                            r_to_cnt <= 8'd0;
         if (r_state != S_MEM_WAIT) r_from_drain <= (r_state == S_DRAIN);
         else                       r_from_drain <= r_from_drain;
         r_flush_all <= (w_next == S_FILL);
         r_halted    <= (w_next == S_HALT);
         r_mem_err   <= r_mem_err | w_timeout;
         if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
         else                                          r_stall_cnt <= r_stall_cnt;
         if (w_flush_evt && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
         else                                          r_flush_cnt <= r_flush_cnt;
      end
   end

   assign bus.pc_write      = w_pc_write;
   assign bus.if_id_write   = w_if_id_write;
   assign bus.if_id_bubble  = w_if_id_bubble;
   assign bus.id_ex_bubble  = w_id_ex_bubble;
   assign bus.id_ex_hold    = w_id_ex_hold;
   assign bus.ex_mem_hold   = w_ex_mem_hold;
   assign bus.mem_wb_bubble = w_mem_wb_bubble;
   assign bus.flush_all     = r_flush_all;
   assign bus.halted        = r_halted;
   assign bus.mem_err       = r_mem_err;
   assign bus.stall_cnt     = r_stall_cnt;
   assign bus.flush_cnt     = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, hand-written corner
// sequences and randomized cycles checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
   localparam int FILL_N  = 4;
   localparam int DRAIN_N = 4;
   localparam int TMO_N   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   pipeline_hazard_ctrl_if bus_if ();

   pipeline_hazard_ctrl #(.FILL_CYCLES(FILL_N), .DRAIN_CYCLES(DRAIN_N), .MEM_TIMEOUT(TMO_N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs, rt;
      logic       ur, mrd;
      logic [4:0] xrt;
      logic       br, acc, rdy;
      logic       pc, ifw, ifb, idb, idh, exh, mwb;
   } vec_t;

   // behavioural model: program position expressed as plain counters and flags
   int m_fill_left, m_drain_done, m_wait, m_stall, m_flush;
   bit m_waiting, m_draining, m_halted, m_err;

   // outputs captured at the last sampling point
   logic c_pc, c_ifw, c_ifb, c_idb, c_idh, c_exh, c_mwb, c_flush, c_halted, c_err;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic m_reset();
      m_fill_left = FILL_N; m_drain_done = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      m_waiting = 1'b0; m_draining = 1'b0; m_halted = 1'b0; m_err = 1'b0;
   endtask

   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic mrd,
                       input logic [4:0] xrt, input logic br, input logic acc, input logic rdy,
                       input logic hr);
      bit frozen, lu;
      bit e_pc, e_ifw, e_ifb, e_idb, e_idh, e_exh, e_mwb;
      bus_if.id_rs = rs; bus_if.id_rt = rt; bus_if.id_uses_rt = ur; bus_if.idex_mem_read = mrd;
      bus_if.idex_rt = xrt; bus_if.ex_branch_taken = br; bus_if.exmem_mem_access = acc;
      bus_if.dmem_ready = rdy; bus_if.halt_req = hr;
      @(negedge clk);
      c_pc = bus_if.pc_write; c_ifw = bus_if.if_id_write; c_ifb = bus_if.if_id_bubble;
      c_idb = bus_if.id_ex_bubble; c_idh = bus_if.id_ex_hold; c_exh = bus_if.ex_mem_hold;
      c_mwb = bus_if.mem_wb_bubble; c_flush = bus_if.flush_all; c_halted = bus_if.halted;
      c_err = bus_if.mem_err;
      frozen = m_waiting ? !rdy : (acc && !rdy);
      lu = mrd && (xrt != 5'd0) && ((xrt == rs) || (ur && (xrt == rt)));
      e_pc = 0; e_ifw = 0; e_ifb = 1; e_idb = 1; e_idh = 0; e_exh = 0; e_mwb = 1;
      if (m_fill_left == 0 && !m_halted) begin
         e_ifb = 0; e_idb = 0; e_mwb = 0;
         if (frozen) begin e_idh = 1; e_exh = 1; e_mwb = 1; end
         else if (br) begin e_pc = !m_draining; e_ifw = 1; e_ifb = 1; e_idb = 1; end
         else if (lu) e_idb = 1;
         else begin e_pc = !m_draining; e_ifw = 1; e_ifb = m_draining; end
      end
      chk("pc_write", c_pc, e_pc);
      chk("if_id_write", c_ifw, e_ifw);
      chk("if_id_bubble", c_ifb, e_ifb);
      chk("id_ex_bubble", c_idb, e_idb);
      chk("id_ex_hold", c_idh, e_idh);
      chk("ex_mem_hold", c_exh, e_exh);
      chk("mem_wb_bubble", c_mwb, e_mwb);
      chk("flush_all", c_flush, (m_fill_left > 0) ? 1 : 0);
      chk("halted", c_halted, m_halted);
      chk("mem_err", c_err, m_err);
      chk("stall_cnt", bus_if.stall_cnt, m_stall);
      chk("flush_cnt", bus_if.flush_cnt, m_flush);
      if (m_fill_left > 0) m_fill_left--;
      else if (!m_halted) begin
         if (frozen) begin
            m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
            if (m_waiting) begin
               m_wait++;
               if (m_wait == TMO_N) begin m_err = 1; m_halted = 1; end
            end else begin
               m_waiting = 1; m_wait = 0;
            end
         end else begin
            m_waiting = 0;
            if (br) m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
            else if (lu) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
            if (m_draining) begin
               m_drain_done++;
               if (m_drain_done == DRAIN_N) m_halted = 1;
            end else if (hr) begin
               m_draining = 1; m_drain_done = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic mem_step(input logic rdy);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, rdy, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus_if.id_rs = 5'd0; bus_if.id_rt = 5'd0; bus_if.id_uses_rt = 1'b0;
      bus_if.idex_mem_read = 1'b0; bus_if.idex_rt = 5'd0; bus_if.ex_branch_taken = 1'b0;
      bus_if.exmem_mem_access = 1'b0; bus_if.dmem_ready = 1'b1; bus_if.halt_req = 1'b0;
      @(negedge clk);
      chk("rst_flush_all", bus_if.flush_all, 1);
      chk("rst_halted", bus_if.halted, 0);
      chk("rst_mem_err", bus_if.mem_err, 0);
      chk("rst_stall_cnt", bus_if.stall_cnt, 0);
      chk("rst_flush_cnt", bus_if.flush_cnt, 0);
      chk("rst_pc_write", bus_if.pc_write, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      vecs[0] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{5'd8, 5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      #2;
      do_reset();

      // fill: flush_all for exactly FILL_N cycles, PC first enabled in the next one
      for (int i = 0; i < FILL_N; i++) begin
         idle();
         chk("fill_flush", c_flush, 1);
         chk("fill_pc", c_pc, 0);
      end
      idle();
      chk("run_first_pc", c_pc, 1);
      chk("run_first_flush", c_flush, 0);

      for (int i = 0; i < 9; i++) begin
         step(vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].mrd, vecs[i].xrt, vecs[i].br,
              vecs[i].acc, vecs[i].rdy, 1'b0);
         chk($sformatf("vec%0d_pc", i), c_pc, vecs[i].pc);
         chk($sformatf("vec%0d_ifw", i), c_ifw, vecs[i].ifw);
         chk($sformatf("vec%0d_ifb", i), c_ifb, vecs[i].ifb);
         chk($sformatf("vec%0d_idb", i), c_idb, vecs[i].idb);
         chk($sformatf("vec%0d_idh", i), c_idh, vecs[i].idh);
         chk($sformatf("vec%0d_exh", i), c_exh, vecs[i].exh);
         chk($sformatf("vec%0d_mwb", i), c_mwb, vecs[i].mwb);
      end
      chk("table_stall_cnt", bus_if.stall_cnt, 2);
      chk("table_flush_cnt", bus_if.flush_cnt, 2);

      // 4-cycle memory access: three frozen cycles, released in the fourth
      for (int i = 0; i < 3; i++) begin
         mem_step(1'b0);
         chk("freeze_idh", c_idh, 1);
         chk("freeze_exh", c_exh, 1);
         chk("freeze_pc", c_pc, 0);
      end
      mem_step(1'b1);
      chk("release_idh", c_idh, 0);
      chk("release_pc", c_pc, 1);
      chk("freeze_stall_cnt", bus_if.stall_cnt, 5);

      // halt request, drain with one frozen cycle in the middle
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle();
      chk("drain1_pc", c_pc, 0);
      mem_step(1'b0);
      chk("drain2_pc", c_pc, 0);
      mem_step(1'b1);
      chk("drain3_pc", c_pc, 0);
      idle();
      chk("drain4_pc", c_pc, 0);
      idle();
      chk("drain5_pc", c_pc, 0);
      chk("drain5_not_halted", c_halted, 0);
      chk("drain_halted", bus_if.halted, 1);
      for (int i = 0; i < 3; i++) begin
         step(5'($urandom_range(0, 3)), 5'd1, 1'b1, 1'b1, 5'd1, 1'($urandom_range(0, 1)),
              1'b1, 1'b0, 1'b0);
         chk("halt_pc", c_pc, 0);
         chk("halt_stays", c_halted, 1);
      end

      // memory timeout
      do_reset();
      for (int i = 0; i < FILL_N; i++) idle();
      mem_step(1'b0);
      for (int i = 0; i < TMO_N; i++) mem_step(1'b0);
      chk("tmo_not_early", c_err, 0);
      chk("tmo_mem_err", bus_if.mem_err, 1);
      chk("tmo_halted", bus_if.halted, 1);
      for (int i = 0; i < 3; i++) begin
         mem_step(1'b1);
         chk("tmo_sticky", c_err, 1);
      end

      // asynchronous reset in the middle of a memory wait
      do_reset();
      for (int i = 0; i < FILL_N; i++) idle();
      for (int i = 0; i < 3; i++) mem_step(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_flush_all", bus_if.flush_all, 1);
      chk("async_stall_cnt", bus_if.stall_cnt, 0);
      chk("async_idh", bus_if.id_ex_hold, 0);
      do_reset();

      // randomized traffic against the model
      for (int r = 0; r < 6; r++) begin
         if (r != 0) do_reset();
         for (int i = 0; i < 80; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 3));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
